dmem_lsu_ctrl: RTL and testbench



---
 rtl/dmem_lsu_pkg.sv | 22 ++
 rtl/lsu_lane_align.sv | 77 +++++++
 rtl/dmem_lsu_ctrl.sv | 143 ++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// =============================================================================
// Module   : dmem_lsu_pkg
// Brief    : Shared funct3 codes and FSM state encoding for the load/store unit.
// Revision : 1.0 - initial release
// =============================================================================
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// =============================================================================
// Module   : lsu_lane_align
// Brief    : Combinational legality check, load lane extract/extend, store merge.
// Revision : 1.0 - initial release
// =============================================================================
module lsu_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic        legal,
  input  logic [2:0]  f3_q,
  input  logic [1:0]  a_lo,
  input  logic [31:0] r_data,
  input  logic [15:0] wd,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic       code_ok;
  logic       aligned;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    code_ok = 1'b0;
    aligned = 1'b1;
    case (funct3)
      F3_B:  code_ok = 1'b1;
      F3_H:  begin code_ok = 1'b1; aligned = ~addr_lo[0]; end
      F3_W:  begin code_ok = 1'b1; aligned = (addr_lo == 2'b00); end
      F3_BU: code_ok = ~we;
      F3_HU: begin code_ok = ~we; aligned = ~addr_lo[0]; end
      default: code_ok = 1'b0;
    endcase
    legal = code_ok & aligned;
  end

  always_comb begin
    case (a_lo)
      2'd0:    byte_sel = r_data[7:0];
      2'd1:    byte_sel = r_data[15:8];
      2'd2:    byte_sel = r_data[23:16];
      default: byte_sel = r_data[31:24];
    endcase
    half_sel = a_lo[1] ? r_data[31:16] : r_data[15:0];

    case (f3_q)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = r_data;
    endcase
  end

  // Only SB/SH reach the merge path, so f3_q[1:0] distinguishes byte vs half.
  always_comb begin
    merge_data = r_data;
    if (f3_q[1:0] == 2'b00) begin
      case (a_lo)
        2'd0:    merge_data[7:0]   = wd[7:0];
        2'd1:    merge_data[15:8]  = wd[7:0];
        2'd2:    merge_data[23:16] = wd[7:0];
        default: merge_data[31:24] = wd[7:0];
      endcase
    end else if (a_lo[1]) begin
      merge_data[31:16] = wd;
    end else begin
      merge_data[15:0] = wd;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : dmem_lsu_ctrl
// Brief    : Load/store sequencer for a word-only single-port data memory.
// Revision : 1.0 - initial release
// =============================================================================
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int END_IDX    = DATA_WIDTH - 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [31:0]      addr,
  input  logic [END_IDX:0] wdata,
  output logic [END_IDX:0] rdata,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [31:0]      mem_addr,
  output logic             mem_w_en,
  output logic [END_IDX:0] mem_w_data,
  input  logic [END_IDX:0] mem_r_data
);

  // Only the 32-bit word configuration is implemented.
  if (DATA_WIDTH != 32 || ADDR_WIDTH > 30) begin : g_unsupported_cfg
  end

  lsu_state_e       state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [15:0]      wd_q, wd_d;
  logic [2:0]       f3_q, f3_d;
  logic             we_q, we_d;
  logic [END_IDX:0] rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             legal;
  logic [END_IDX:0] load_data;
  logic [END_IDX:0] merge_data;

  lsu_lane_align u_lane_align (
    .we         (we),
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .legal      (legal),
    .f3_q       (f3_q),
    .a_lo       (a_q[1:0]),
    .r_data     (mem_r_data),
    .wd         (wd_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    wd_d       = wd_q;
    f3_d       = f3_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_w_en   = 1'b0;
    mem_w_data = wdata;
    mem_addr   = (state_q == IDLE) ? addr : a_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          a_d  = addr;
          wd_d = wdata[15:0];
          f3_d = funct3;
          we_d = we;
          if (!legal) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (we && funct3 == F3_W) begin
            mem_w_en = 1'b1;
            state_d  = RESP;
            done_d   = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        // Read data for a_q is valid this cycle: finish a load or write back the merge.
        if (we_q) begin
          mem_w_en   = 1'b1;
          mem_w_data = merge_data;
        end else begin
          rdata_d = load_data;
        end
        state_d = RESP;
        done_d  = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_w_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_dmem_lsu_ctrl
// Brief    : Scoreboard bench for dmem_lsu_ctrl with a 1-cycle word memory model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_rd = 32'd0;

  typedef struct { logic [31:0] rd; logic er; int at; } exp_t;
  typedef struct { int at; logic [31:0] a; logic [31:0] d; } wr_t;
  exp_t sb[$];
  wr_t  wr_log[$];

  logic [31:0] mem [0:255];
  logic [7:0]  raddr_q = 8'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr[9:2]] <= mem_w_data;
    raddr_q <= mem_addr[9:2];
  end
  assign mem_r_data = mem[raddr_q];

  dmem_lsu_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: logs writes and pops the scoreboard on every done pulse.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (mem_w_en) wr_log.push_back('{cyc, mem_addr, mem_w_data});
    if (mem_w_en && done) begin
      checks++; errors++;
      $display("FAIL write_in_resp: mem_w_en=1 with done=1 at cycle %0d", cyc);
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (cyc != e.at) begin
          errors++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, e.at);
        end
        checks++;
        if (rdata !== e.rd) begin
          errors++;
          $display("FAIL rdata: got %08h expected %08h", rdata, e.rd);
        end
        checks++;
        if (err !== e.er) begin
          errors++;
          $display("FAIL err: got %0b expected %0b", err, e.er);
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      drive_edge();
      sample();
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: %0d responses never arrived", sb.size());
      sb.delete();
    end
  endtask

  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_er, input int lat, output int n);
    drive_edge();
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    n = cyc;
    sb.push_back('{exp_rd, exp_er, n + lat});
    sample();
    drive_edge();
    req = 1'b0;
    sample();
    wait_drain();
  endtask

  task automatic test_reset();
    repeat (3) begin drive_edge(); sample(); end
    checks += 5;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %08h expected 0", rdata); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    if (mem_w_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", mem_w_en); end
    drive_edge();
    rst = 1'b0;
    sample();
  endtask

  task automatic test_sw_lw();
    int n;
    wr_log.delete();
    access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, last_rd, 1'b0, 1, n);
    checks++;
    if (wr_log.size() != 1 || wr_log[0].at != n || wr_log[0].a[9:2] != 8'h04 ||
        wr_log[0].d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_write: writes=%0d first=%08h expected one write of deadbeef in cycle %0d",
               wr_log.size(), (wr_log.size() != 0) ? wr_log[0].d : 32'd0, n);
    end
    last_rd = 32'hDEADBEEF;
    access(1'b0, 3'd2, 32'h10, 32'd0, last_rd, 1'b0, 2, n);
  endtask

  task automatic test_byte();
    int n;
    wr_log.delete();
    access(1'b1, 3'd0, 32'h12, 32'h00000055, last_rd, 1'b0, 2, n);
    checks++;
    if (wr_log.size() != 1 || wr_log[0].at != n + 1 || wr_log[0].d !== 32'hDE55BEEF) begin
      errors++;
      $display("FAIL sb_merge: writes=%0d first=%08h expected one write of de55beef in cycle %0d",
               wr_log.size(), (wr_log.size() != 0) ? wr_log[0].d : 32'd0, n + 1);
    end
    last_rd = 32'h00000055; access(1'b0, 3'd0, 32'h12, 32'd0, last_rd, 1'b0, 2, n);
    last_rd = 32'hFFFFFFDE; access(1'b0, 3'd0, 32'h13, 32'd0, last_rd, 1'b0, 2, n);
    last_rd = 32'h000000DE; access(1'b0, 3'd4, 32'h13, 32'd0, last_rd, 1'b0, 2, n);
  endtask

  task automatic test_half();
    int n;
    wr_log.delete();
    access(1'b1, 3'd1, 32'h10, 32'h12348001, last_rd, 1'b0, 2, n);
    checks++;
    if (wr_log.size() != 1 || wr_log[0].at != n + 1 || mem[4] !== 32'hDE558001) begin
      errors++;
      $display("FAIL sh_merge: writes=%0d mem=%08h expected one write, mem de558001",
               wr_log.size(), mem[4]);
    end
    last_rd = 32'hFFFF8001; access(1'b0, 3'd1, 32'h10, 32'd0, last_rd, 1'b0, 2, n);
    last_rd = 32'h00008001; access(1'b0, 3'd5, 32'h10, 32'd0, last_rd, 1'b0, 2, n);
  endtask

  task automatic test_illegal();
    int n;
    wr_log.delete();
    last_rd = 32'd0;
    access(1'b0, 3'd2, 32'h11, 32'd0, 32'd0, 1'b1, 1, n);
    access(1'b1, 3'd1, 32'h13, 32'hFFFF, 32'd0, 1'b1, 1, n);
    access(1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, 1, n);
    access(1'b1, 3'd2, 32'h12, 32'h0BADF00D, 32'd0, 1'b1, 1, n);
    access(1'b1, 3'd4, 32'h10, 32'h0BADF00D, 32'd0, 1'b1, 1, n);
    checks++;
    if (wr_log.size() != 0 || mem[4] !== 32'hDE558001) begin
      errors++;
      $display("FAIL illegal_nowrite: writes=%0d mem=%08h expected 0 writes, mem de558001",
               wr_log.size(), mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] bz;
    access(1'b1, 3'd2, 32'h14, 32'h11223344, last_rd, 1'b0, 1, n);
    wr_log.delete();
    drive_edge();
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h14; wdata = 32'h000000AA;
    n = cyc;
    sb.push_back('{last_rd, 1'b0, n + 2});
    sample(); bz[0] = busy;
    drive_edge(); sample(); bz[1] = busy;
    drive_edge();
    we = 1'b0; funct3 = 3'd0; addr = 32'h14;
    sb.push_back('{32'hFFFFFFAA, 1'b0, n + 5});
    sample(); bz[2] = busy;
    drive_edge(); sample(); bz[3] = busy;
    drive_edge();
    req = 1'b0;
    sample();
    wait_drain();
    last_rd = 32'hFFFFFFAA;
    checks++;
    if (bz !== 4'b0110) begin
      errors++;
      $display("FAIL held_busy: got %04b (cycles 3..0) expected 0110", bz);
    end
    checks++;
    if (wr_log.size() != 1 || wr_log[0].at != n + 1 || mem[5] !== 32'h112233AA) begin
      errors++;
      $display("FAIL held_single_write: writes=%0d mem=%08h expected 1 write, mem 112233aa",
               wr_log.size(), mem[5]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    access(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, last_rd, 1'b0, 1, n);
    wr_log.delete();
    drive_edge();
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h20; wdata = 32'h00000077;
    sample();
    drive_edge();
    req = 1'b0; addr = 32'd0; rst = 1'b1;
    sample();
    checks++;
    if (mem_w_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_wen: got %0b expected 0", mem_w_en);
    end
    drive_edge();
    rst = 1'b0;
    sample();
    checks++;
    if ({rdata, done, err, busy, mem_w_en} !== 36'd0) begin
      errors++;
      $display("FAIL rst_rd_outputs: rdata=%08h done=%0b err=%0b busy=%0b wen=%0b expected all 0",
               rdata, done, err, busy, mem_w_en);
    end
    drive_edge(); sample();
    checks++;
    if (wr_log.size() != 0 || mem[8] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_rd_mem: writes=%0d mem=%08h expected 0 writes, mem cafef00d",
               wr_log.size(), mem[8]);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
